// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage with MEM/WB register, load alignment, tohost CSR and counters.
module wb_stage #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [11:0] CSR_TOHOST = 12'h51E,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_pc4,
  input  logic [31:0]      mem_inst,
  input  logic             mem_valid,
  input  logic [31:0]      mem_rs1_data,
  input  logic [31:0]      mem_bios_dout,
  input  logic [31:0]      mem_dmem_dout,
  input  logic [31:0]      mem_uart_dout,
  output logic [31:0]      wb_wdata,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic [31:0]      wb_inst,
  output logic [31:0]      csr_tohost,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_LOAD = 7'h03, OP_OP = 7'h33, OP_IMM = 7'h13, OP_SYS = 7'h73;
  logic [31:0] alu, pc4, rs1, word, ld, csr_rd;
  logic        valid, is_csr, retire, writes;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [11:0] csr;
  logic [15:0] half;
  logic [7:0]  lb;
  assign opc    = wb_inst[6:0];
  assign f3     = wb_inst[14:12];
  assign csr    = wb_inst[31:20];
  assign wb_rd  = wb_inst[11:7];
  assign is_csr = opc == OP_SYS && f3 != 3'd0;
  assign retire = valid & ~stall;
  assign writes = (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OP, OP_IMM}) | is_csr;
  assign wb_we  = retire & writes & (wb_rd != 5'd0);
  // Region decode on the top nibble; 0x1 and 0x3 both alias DMEM
  assign word = (alu[31:30] == 2'b00 && alu[28]) ? mem_dmem_dout :
                alu[31:28] == 4'b0100 ? mem_bios_dout :
                alu[31:28] == 4'b1000 ? mem_uart_dout : 32'd0;
  assign lb   = 8'(word >> {alu[1:0], 3'b000});
  assign half = alu[1] ? word[31:16] : word[15:0];
  assign ld   = f3[1:0] == 2'b00 ? {{24{~f3[2] & lb[7]}}, lb} :
                f3[1:0] == 2'b01 ? {{16{~f3[2] & half[15]}}, half} : word;
  assign csr_rd = csr == CSR_TOHOST ? csr_tohost :
                  csr == 12'hC00    ? 32'(cycle_cnt) :
                  csr == 12'hC02    ? 32'(instret_cnt) : 32'd0;
  assign wb_wdata = (opc == OP_JAL || opc == OP_JALR) ? pc4 :
                    opc == OP_LOAD ? ld :
                    is_csr ? csr_rd : alu;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu     <= '0;
      pc4     <= '0;
      rs1     <= '0;
      wb_inst <= NOP_INST;
      valid   <= 1'b0;
    end else if (flush) begin
      alu     <= '0;
      pc4     <= '0;
      rs1     <= '0;
      wb_inst <= NOP_INST;
      valid   <= 1'b0;
    end else if (!stall) begin
      alu     <= mem_alu;
      pc4     <= mem_pc4;
      rs1     <= mem_rs1_data;
      wb_inst <= mem_inst;
      valid   <= mem_valid;
    end
  // Only CSRRW (001) and CSRRWI (101) write tohost; the read above sees the old value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csr_tohost  <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
      if (retire && is_csr && csr == CSR_TOHOST && f3[1:0] == 2'b01)
        csr_tohost <= f3[2] ? {27'd0, wb_inst[19:15]} : rs1;
    end
endmodule
